// File: rtl/csr_uart_rx.sv
// csr_uart_rx: 8N1 UART receiver with byte FIFO, read-to-pop CSR at BASE_ADDR.
// Define CSR_UART_RX_IRQ_EN to generate the registered receive interrupt.
module csr_uart_rx #(
  parameter logic [11:0] BASE_ADDR = 12'hBC0,
  parameter int DIVISOR = 868,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        irq
);
  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] HALF = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIVISOR - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, BRK = 3'd4;
  logic rx_q, rxs;
  logic [2:0] state, nbit;
  logic [CW-1:0] cnt;
  logic [7:0] sh;
  logic [7:0] mem [2**FIFO_AW];
  logic [FIFO_AW:0] wp, rp;
  logic ovr, ferr, hit_q;
  logic tick, push, frame_err, empty, full, hit, pop, wr_ok, clr;
  logic unused_wdata;
  assign unused_wdata = ^{wdata[31:11], wdata[8:0]};
  assign tick = cnt == '0;
  assign push = state == STOP && tick && rxs;
  assign frame_err = state == STOP && tick && !rxs;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {FIFO_AW{1'b0}}};
  assign hit = read && addr == BASE_ADDR;
  assign pop = hit && !empty;
  // a full FIFO still accepts a push when the same edge pops the head
  assign wr_ok = push && (!full || pop);
  assign clr = hit_q && modify == 3'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q <= 1'b1;
      rxs <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      nbit <= '0;
      sh <= '0;
    end else begin
      rx_q <= rx;
      rxs <= rx_q;
      cnt <= tick ? cnt : cnt - 1'b1;
      case (state)
        IDLE: if (!rxs) begin
          cnt <= HALF;
          state <= START;
        end
        START: if (tick) begin
          cnt <= FULL;
          nbit <= '0;
          state <= rxs ? IDLE : DATA;
        end
        DATA: if (tick) begin
          sh <= {rxs, sh[7:1]};
          cnt <= FULL;
          nbit <= nbit + 3'd1;
          state <= nbit == 3'd7 ? STOP : DATA;
        end
        STOP: if (tick) state <= rxs ? IDLE : BRK;
        BRK: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) if (wr_ok) mem[wp[FIFO_AW-1:0]] <= sh;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      ovr <= 1'b0;
      ferr <= 1'b0;
      hit_q <= 1'b0;
      valid <= 1'b0;
      rdata <= '0;
    end else begin
      wp <= wr_ok ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      ovr <= (push && full && !pop) || (ovr && !(clr && wdata[9]));
      ferr <= frame_err || (ferr && !(clr && wdata[10]));
      hit_q <= addr == BASE_ADDR;
      valid <= hit;
      rdata <= hit ? {21'b0, ferr, ovr, empty, empty ? 8'h00 : mem[rp[FIFO_AW-1:0]]} : '0;
    end
  end
`ifdef CSR_UART_RX_IRQ_EN
  always_ff @(posedge clk) irq <= rst ? 1'b0 : (!empty || ovr || ferr);
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_csr_uart_rx.sv
// tb_csr_uart_rx: vector table plus hand sequences; read results checked via a scoreboard queue.
module tb_csr_uart_rx;
  localparam int DIV = 8;
  localparam logic [11:0] BASE = 12'hBC0;
`ifdef CSR_UART_RX_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif
  logic clk = 0, rst = 1, read = 0, rx = 1;
  logic [2:0] modify = 0;
  logic [31:0] wdata = 0;
  logic [11:0] addr = 0;
  logic [31:0] rdata;
  logic valid, irq;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  typedef struct {
    bit send;
    logic [7:0] data;
    bit stop;
    bit wr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[7];

  csr_uart_rx #(.BASE_ADDR(BASE), .DIVISOR(DIV), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .read(read), .modify(modify), .wdata(wdata),
    .addr(addr), .rdata(rdata), .valid(valid), .rx(rx), .irq(irq));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got rdata %h with no read pending", rdata);
      end else check("read", rdata, exp_q.pop_front());
    end else check("idle_rdata", rdata, 32'h0);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      idle(DIV);
    end
    rx = 1'b1;
  endtask

  task automatic do_read(input logic [31:0] exp);
    read = 1'b1;
    addr = BASE;
    exp_q.push_back(exp);
    @(negedge clk);
    read = 1'b0;
    addr = 12'h0;
  endtask

  task automatic do_write(input logic [31:0] d);
    addr = BASE;
    @(negedge clk);
    addr = 12'h0;
    modify = 3'd1;
    wdata = d;
    @(negedge clk);
    modify = 3'd0;
    wdata = 32'h0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1, 8'hA5, 1, 0, 32'h0, 32'h0A5};
    vt[1] = '{0, 8'h00, 1, 0, 32'h0, 32'h100};
    vt[2] = '{1, 8'h3C, 0, 0, 32'h0, 32'h500};
    vt[3] = '{0, 8'h00, 1, 1, 32'h400, 32'h100};
    vt[4] = '{1, 8'h5A, 1, 0, 32'h0, 32'h05A};
    vt[5] = '{1, 8'hFF, 1, 0, 32'h0, 32'h0FF};
    vt[6] = '{1, 8'h00, 1, 0, 32'h0, 32'h000};
    idle(3);
    check("rst_rdata", rdata, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    idle(4);
    for (int i = 0; i < 7; i++) begin
      if (vt[i].send) send(vt[i].data, vt[i].stop);
      if (vt[i].wr) do_write(vt[i].wd);
      idle(2);
      do_read(vt[i].exp);
      idle(1);
    end
    read = 1'b1;
    addr = BASE + 12'h1;
    @(negedge clk);
    read = 1'b0;
    addr = 12'h0;
    check("wrong_addr_valid", {31'b0, valid}, 32'h0);
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(20);
    do_read(32'h100);
    idle(2);
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    idle(2);
    for (int i = 1; i <= 4; i++) do_read(32'h200 | 32'(i));
    do_read(32'h300);
    do_write(32'h200);
    do_read(32'h100);
    idle(2);
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b1);
    fork
      send(8'h15, 1'b1);
      begin
        idle(78);
        do_read(32'h011);
      end
    join
    idle(2);
    for (int i = 0; i < 4; i++) do_read(32'h012 + 32'(i));
    do_read(32'h100);
    idle(2);
    send(8'h42, 1'b1);
    rx = 1'b0;
    idle(DIV);
    rx = 1'b1;
    idle(DIV);
    rx = 1'b0;
    idle(10);
    rst = 1'b1;
    rx = 1'b1;
    idle(2);
    rst = 1'b0;
    check("midframe_rst_valid", {31'b0, valid}, 32'h0);
    idle(20);
    do_read(32'h100);
    idle(2);
    send(8'hC3, 1'b1);
    idle(2);
    do_read(32'h0C3);
    idle(2);
    fork
      send(8'h66, 1'b1);
      begin
        idle(79);
        check("irq_before_push", {31'b0, irq}, 32'h0);
        idle(1);
        check("irq_after_push", {31'b0, irq}, {31'b0, IRQ});
      end
    join
    idle(2);
    do_read(32'h066);
    check("irq_at_pop", {31'b0, irq}, {31'b0, IRQ});
    idle(1);
    check("irq_after_pop", {31'b0, irq}, 32'h0);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d reads outstanding expected 0", exp_q.size());
    end
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
